// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, state type and hex segment table
// for the seven-segment scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam int         NDIG    = 4;

  typedef enum logic {
    ST_OFF,
    ST_SCAN
  } state_t;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low
// seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: 4-digit multiplexed display driver with
// per-frame snapshot, blanking and blinking.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX =
    FW'(BLINK_FRAMES - 1);

  state_t          r_state;
  state_t          w_state_nx;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx_nx;
  logic [15:0]     r_data_s;
  logic [3:0]      r_blank_s;
  logic [3:0]      r_blink_s;
  logic [FW-1:0]   r_frm;
  logic            r_phase;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_fs;

  logic            w_tick;
  logic            w_bound;
  logic            w_phase_nx;
  logic [15:0]     w_data_sel;
  logic [3:0]      w_blank_sel;
  logic [3:0]      w_blink_sel;
  logic [3:0]      w_nib;
  logic [6:0]      w_seg;
  logic            w_dark;

  assign w_tick = (r_cnt == CNT_MAX);

  // Next state and next digit index, advanced on tick.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    if (w_tick) begin
      unique case (r_state)
        ST_OFF: begin
          w_state_nx = ST_SCAN;
          w_idx_nx   = 2'd0;
        end
        ST_SCAN: begin
          w_idx_nx = r_idx + 2'd1;
        end
        default: begin
          w_state_nx = ST_OFF;
          w_idx_nx   = 2'd0;
        end
      endcase
    end
  end

  // Frame-edge bypass so digit 0 matches the new snapshot.
  always_comb begin
    w_bound     = w_tick && (w_idx_nx == 2'd0);
    w_data_sel  = w_bound ? data  : r_data_s;
    w_blank_sel = w_bound ? blank : r_blank_s;
    w_blink_sel = w_bound ? blink : r_blink_s;
    w_phase_nx  = (w_bound && r_frm == FRM_MAX)
                ? ~r_phase : r_phase;
    w_nib       = 4'(w_data_sel >> {w_idx_nx, 2'b00});
    w_dark      = w_blank_sel[w_idx_nx]
                | (w_blink_sel[w_idx_nx] & w_phase_nx);
  end

  seg7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Divider, FSM state, snapshots, blink and digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_state   <= ST_OFF;
      r_idx     <= 2'd0;
      r_data_s  <= '0;
      r_blank_s <= '0;
      r_blink_s <= '0;
      r_frm     <= '0;
      r_phase   <= 1'b0;
      r_an      <= AN_OFF;
      r_seg     <= SEG_OFF;
      r_fs      <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_fs    <= w_bound;
      if (w_bound) begin
        r_data_s  <= data;
        r_blank_s <= blank;
        r_blink_s <= blink;
        r_frm     <= (r_frm == FRM_MAX)
                   ? '0 : r_frm + 1'b1;
        r_phase   <= w_phase_nx;
      end
      if (w_tick) begin
        r_an  <= w_dark ? AN_OFF
               : ~(4'b0001 << w_idx_nx);
        r_seg <= w_dark ? SEG_OFF : w_seg;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = 1'b1;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: vector table, hand sequences and random
// stimulus against a frame-level reference model.
module tb_seg7_scanner;

  localparam int RD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seg7_scanner #(
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .blank       (blank),
    .blink       (blink),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: m_t = edges since reset; every RD-th edge is a
  // digit slot, every 4th slot starts frame m_b.
  int          m_t;
  int          m_b;
  logic [15:0] m_data;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fs;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int s, d, ph;
    logic dark;
    if (rst) begin
      m_t = 0; m_b = 0;
      m_data = '0; m_blank = '0; m_blink = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_fs = 1'b0;
    end else begin
      m_t++;
      e_fs = 1'b0;
      if (m_t % RD == 0) begin
        s = m_t / RD;
        d = (s - 1) % 4;
        if (d == 0) begin
          m_b++;
          m_data = data; m_blank = blank; m_blink = blink;
          e_fs = 1'b1;
        end
        ph = (m_b / BF) % 2;
        dark = m_blank[d] || (m_blink[d] && ph == 1);
        e_an = dark ? 4'hF : ~(4'(1) << d);
        e_seg = dark ? 7'h7F
              : seg_ref[(m_data >> (4 * d)) & 16'hF];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("an", an, e_an);
    chk("seg", seg, e_seg);
    chk("dp", dp, 1'b1);
    chk("frame_start", frame_start, e_fs);
  endtask

  task automatic to_boundary();
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * RD + 2; i++) begin
      cyc();
      if (m_t % (4 * RD) == RD) begin
        hit = 1;
        break;
      end
    end
    chk("boundary_timeout", hit, 1'b1);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  bl;
    int          idx;
    logic [3:0]  x_an;
    logic [6:0]  x_seg;
  } vec_t;

  vec_t vt [9];
  int   dark_cnt;

  initial begin
    vt[0] = '{16'h1A80, 4'b0000, 0, 4'b1110, 7'b1000000};
    vt[1] = '{16'h1A80, 4'b0000, 1, 4'b1101, 7'b0000000};
    vt[2] = '{16'h1A80, 4'b0000, 2, 4'b1011, 7'b0001000};
    vt[3] = '{16'h1A80, 4'b0000, 3, 4'b0111, 7'b1111001};
    vt[4] = '{16'h1234, 4'b0000, 0, 4'b1110, 7'b0011001};
    vt[5] = '{16'h1234, 4'b0000, 1, 4'b1101, 7'b0110000};
    vt[6] = '{16'h1234, 4'b0101, 0, 4'b1111, 7'h7F};
    vt[7] = '{16'hFFFF, 4'b0000, 2, 4'b1011, 7'b0001110};
    vt[8] = '{16'hC0DE, 4'b0000, 3, 4'b0111, 7'b1000110};

    rst = 1'b1; data = 16'h1A80; blank = '0; blink = '0;

    // Reset held for three cycles, then four after release.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_fs", frame_start, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_an", an, 4'hF);
      chk("post_rst_seg", seg, 7'h7F);
    end
    cyc();
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b1000000);
    chk("first_fs", frame_start, 1'b1);

    // Table vectors.
    foreach (vt[k]) begin
      data = vt[k].d; blank = vt[k].bl; blink = '0;
      to_boundary();
      for (int i = 0; i < RD * vt[k].idx; i++) cyc();
      chk($sformatf("vec%0d_an", k), an, vt[k].x_an);
      chk($sformatf("vec%0d_seg", k), seg, vt[k].x_seg);
    end

    // Snapshot: change data while digit 1 is shown.
    data = 16'h1234; blank = '0;
    to_boundary();
    for (int i = 0; i < RD; i++) cyc();
    chk("snap_d1_an", an, 4'b1101);
    data = 16'hFFFF;
    for (int i = 0; i < RD; i++) cyc();
    chk("snap_d2_seg", seg, 7'b0100100);
    for (int i = 0; i < RD; i++) cyc();
    chk("snap_d3_seg", seg, 7'b1111001);
    for (int i = 0; i < RD; i++) cyc();
    chk("snap_next_an", an, 4'b1110);
    chk("snap_next_seg", seg, 7'b0001110);
    chk("snap_next_fs", frame_start, 1'b1);

    // Blank: digits 0 and 2 never light.
    blank = 4'b0101;
    to_boundary();
    for (int i = 0; i < 4 * RD; i++) begin
      chk("blank_an", an & 4'b0101, 4'b0101);
      cyc();
    end

    // Blink: over eight frames digit 3 is dark in four.
    blank = '0; blink = 4'b1000; data = 16'h5555;
    to_boundary();
    dark_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 3 * RD; i++) cyc();
      if (an == 4'hF) dark_cnt++;
      to_boundary();
    end
    chk("blink_dark_frames", dark_cnt, 4);

    // Reset during digit 2.
    blink = '0;
    to_boundary();
    for (int i = 0; i < 2 * RD + 1; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    rst = 1'b0;
    for (int i = 0; i < RD - 1; i++) begin
      cyc();
      chk("midrst_dark", an, 4'hF);
    end
    cyc();
    chk("midrst_restart_an", an, 4'b1110);

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) data = 16'($urandom);
      if ($urandom_range(31) == 0) blank = 4'($urandom);
      if ($urandom_range(31) == 0) blink = 4'($urandom);
      rst = ($urandom_range(299) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
